// File: rtl/fadd_wb_buffer.sv
// Writeback buffer behind the FP adder: a small result FIFO toward the register
// file plus per-warp sticky fflags that the warp scheduler can read and clear.

module fadd_wb_flag_slot (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_en,
  input  logic [4:0] set_flags,
  input  logic       clr,
  output logic [4:0] flags
);
  // Clear takes effect before the OR, so a same-cycle push survives the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      flags <= '0;
    else if (clr)    flags <= set_en ? set_flags : 5'd0;
    else if (set_en) flags <= flags | set_flags;
  end
endmodule

module fadd_wb_buffer #(
  parameter  int EXPWIDTH   = 5,
  parameter  int PRECISION  = 3,
  parameter  int DEPTH_WARP = 4,
  parameter  int FIFO_DEPTH = 4,
  localparam int DW         = EXPWIDTH + PRECISION + 1,
  localparam int NUM_WARP   = 2 ** DEPTH_WARP,
  localparam int CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DW-1:0]         in_result_i,
  input  logic [4:0]            in_fflags_i,
  input  logic [7:0]            in_reg_idxw_i,
  input  logic [DEPTH_WARP-1:0] in_warpid_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DW-1:0]         out_result_o,
  output logic [7:0]            out_reg_idxw_o,
  output logic [DEPTH_WARP-1:0] out_warpid_o,
  input  logic                  clr_valid_i,
  input  logic [DEPTH_WARP-1:0] clr_warpid_i,
  input  logic [DEPTH_WARP-1:0] rd_warpid_i,
  output logic [4:0]            rd_fflags_o,
  output logic [CW-1:0]         count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [DW-1:0]         result;
    logic [7:0]            reg_idxw;
    logic [DEPTH_WARP-1:0] warpid;
  } entry_t;

  entry_t        mem [FIFO_DEPTH];
  entry_t        head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop;

  // Ready comes only from registered occupancy: no full-bypass on a same-cycle pop.
  assign in_ready_o  = rst_n && (count < CW'(FIFO_DEPTH));
  assign out_valid_o = (count != '0);
  assign push        = in_valid_i && in_ready_o;
  assign pop         = out_valid_o && out_ready_i;
  assign count_o     = count;

  assign head           = mem[rd_ptr];
  assign out_result_o   = head.result;
  assign out_reg_idxw_o = head.reg_idxw;
  assign out_warpid_o   = head.warpid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= '{result: in_result_i, reg_idxw: in_reg_idxw_i, warpid: in_warpid_i};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  logic [NUM_WARP-1:0][4:0] acc;

  for (genvar w = 0; w < NUM_WARP; w++) begin : g_warp
    fadd_wb_flag_slot u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .set_en    (push && (in_warpid_i == DEPTH_WARP'(w))),
      .set_flags (in_fflags_i),
      .clr       (clr_valid_i && (clr_warpid_i == DEPTH_WARP'(w))),
      .flags     (acc[w])
    );
  end

  // Registered read returns the value held before this edge's updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_fflags_o <= '0;
    else        rd_fflags_o <= acc[rd_warpid_i];
  end
endmodule

// File: tb/tb_fadd_wb_buffer.sv
// Randomized and directed bench for fadd_wb_buffer against a queue/array model.

module tb_fadd_wb_buffer;
  logic       clk = 0;
  logic       rst_n;
  logic       in_valid_i, out_ready_i, clr_valid_i;
  logic       in_ready_o, out_valid_o;
  logic [8:0] in_result_i, out_result_o;
  logic [4:0] in_fflags_i, rd_fflags_o;
  logic [7:0] in_reg_idxw_i, out_reg_idxw_o;
  logic [3:0] in_warpid_i, out_warpid_o, clr_warpid_i, rd_warpid_i;
  logic [2:0] count_o;

  always #5 clk = ~clk;

  fadd_wb_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_result_i(in_result_i),
    .in_fflags_i(in_fflags_i), .in_reg_idxw_i(in_reg_idxw_i), .in_warpid_i(in_warpid_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_result_o(out_result_o),
    .out_reg_idxw_o(out_reg_idxw_o), .out_warpid_o(out_warpid_o),
    .clr_valid_i(clr_valid_i), .clr_warpid_i(clr_warpid_i),
    .rd_warpid_i(rd_warpid_i), .rd_fflags_o(rd_fflags_o), .count_o(count_o)
  );

  int n_cmp = 0, n_err = 0;
  logic [20:0] q_m[$];      // {result, reg_idxw, warpid}
  logic [4:0]  acc_m[16];
  logic [4:0]  rd_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_out();
    chk("out_valid", out_valid_o, q_m.size() != 0);
    if (q_m.size() != 0)
      chk("out_head", {out_result_o, out_reg_idxw_o, out_warpid_o}, q_m[0]);
  endtask

  // One clock: apply inputs just after negedge, advance model at posedge, check at next negedge.
  task automatic drive(input logic v, input logic [8:0] d, input logic [4:0] f, input logic [7:0] r,
                       input logic [3:0] w, input logic ordy, input logic clr,
                       input logic [3:0] cw, input logic [3:0] rw);
    logic push, pop;
    in_valid_i = v; in_result_i = d; in_fflags_i = f; in_reg_idxw_i = r; in_warpid_i = w;
    out_ready_i = ordy; clr_valid_i = clr; clr_warpid_i = cw; rd_warpid_i = rw;
    #1;
    chk("in_ready", in_ready_o, q_m.size() < 4);
    chk_out();
    push = v && (q_m.size() < 4);
    pop  = ordy && (q_m.size() != 0);
    rd_m = acc_m[rw];
    @(posedge clk);
    if (pop) void'(q_m.pop_front());
    if (push) q_m.push_back({d, r, w});
    if (clr) acc_m[cw] = 5'd0;
    if (push) acc_m[w] = acc_m[w] | f;
    @(negedge clk);
    chk("count", count_o, q_m.size());
    chk("rd_fflags", rd_fflags_o, rd_m);
    chk_out();
  endtask

  task automatic push_one(input logic [8:0] d, input logic ordy);
    drive(1, d, 5'd0, d[7:0] ^ 8'h5A, 4'd1, ordy, 0, 4'd0, 4'd0);
  endtask

  task automatic idle(input logic ordy, input logic [3:0] rw);
    drive(0, 9'd0, 5'd0, 8'd0, 4'd0, ordy, 0, 4'd0, rw);
  endtask

  task automatic model_reset();
    q_m.delete();
    for (int i = 0; i < 16; i++) acc_m[i] = 5'd0;
  endtask

  initial begin
    rst_n = 0;
    in_valid_i = 0; in_result_i = 0; in_fflags_i = 0; in_reg_idxw_i = 0; in_warpid_i = 0;
    out_ready_i = 0; clr_valid_i = 0; clr_warpid_i = 0; rd_warpid_i = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_count", count_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_ready", in_ready_o, 0);
    chk("rst_result", out_result_o, 0);
    chk("rst_rd", rd_fflags_o, 0);
    rst_n = 1;
    #1 chk("rel_ready", in_ready_o, 1);
    @(negedge clk);

    // Three results held, then drained in order.
    push_one(9'h03C, 0); push_one(9'h040, 0); push_one(9'h044, 0);
    chk("three_count", count_o, 3);
    repeat (4) idle(1, 4'd0);
    chk("drain_valid", out_valid_o, 0);

    // Fill, blocked 5th push, pop one, 5th then accepted and drains last.
    for (int i = 0; i < 4; i++) push_one(9'h100 + 9'(i), 0);
    chk("full_ready", in_ready_o, 0);
    push_one(9'h1F5, 0);
    push_one(9'h1F5, 1);   // pop while full: push still refused
    push_one(9'h1F5, 0);   // accepted now
    repeat (5) idle(1, 4'd0);

    // Streaming with one entry resident, wrapping the pointers.
    push_one(9'h080, 0);
    for (int i = 0; i < 16; i++) begin
      push_one(9'h081 + 9'(i), 1);
      chk("stream_count", count_o, 1);
    end
    idle(1, 4'd0);

    // Sticky flags for warp 2, warp 3 untouched.
    drive(1, 9'h011, 5'b00001, 8'h02, 4'd2, 1, 0, 4'd0, 4'd2);
    drive(1, 9'h012, 5'b00100, 8'h02, 4'd2, 1, 0, 4'd0, 4'd2);
    idle(1, 4'd2);
    chk("warp2_flags", rd_fflags_o, 5'b00101);
    idle(1, 4'd3);
    chk("warp3_flags", rd_fflags_o, 5'b00000);

    // Clear and push to the same warp in one cycle.
    drive(1, 9'h013, 5'b00010, 8'h02, 4'd2, 1, 1, 4'd2, 4'd2);
    idle(1, 4'd2);
    chk("clr_push_flags", rd_fflags_o, 5'b00010);

    // Mid-operation reset with three entries queued.
    idle(1, 4'd0);
    push_one(9'h0A1, 0); push_one(9'h0A2, 0); push_one(9'h0A3, 0);
    rst_n = 0;
    #1;
    chk("mid_rst_count", count_o, 0);
    chk("mid_rst_valid", out_valid_o, 0);
    chk("mid_rst_rd", rd_fflags_o, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    push_one(9'h0B7, 0);
    chk("post_rst_count", count_o, 1);
    idle(1, 4'd0);
    idle(1, 4'd0);

    // Random traffic.
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 3) != 0, 9'($urandom), 5'($urandom), 8'($urandom),
            4'($urandom_range(0, 3)), $urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0,
            4'($urandom_range(0, 3)), 4'($urandom_range(0, 4)));
    repeat (6) idle(1, 4'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
